// File: rtl/axi_lite_settings_bridge_pkg.sv
// Shared state encodings and AXI response codes for the AXI-Lite to
// settings-bus bridge.
package axi_lite_settings_bridge_pkg;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_STROBE = 2'd1,
    W_RESP   = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_STROBE = 2'd1,
    R_RESP   = 2'd2
  } r_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_settings_bridge.sv
// AXI-Lite slave that turns single-beat writes/reads into one-cycle strobes
// on a simple settings bus. Write and read paths run as independent FSMs.
module axi_lite_settings_bridge
  import axi_lite_settings_bridge_pkg::*;
#(
  parameter int C_DATAWIDTH = 32,
  parameter int C_ADDRWIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic [C_ADDRWIDTH-1:0]     s_axi_awaddr,
  input  logic                       s_axi_awvalid,
  output logic                       s_axi_awready,

  input  logic [C_DATAWIDTH-1:0]     s_axi_wdata,
  input  logic [C_DATAWIDTH/8-1:0]   s_axi_wstrb,
  input  logic                       s_axi_wvalid,
  output logic                       s_axi_wready,

  output logic [1:0]                 s_axi_bresp,
  output logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,

  input  logic [C_ADDRWIDTH-1:0]     s_axi_araddr,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,

  output logic [C_DATAWIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,

  output logic [C_DATAWIDTH-1:0]     set_data,
  output logic [C_ADDRWIDTH-1:0]     set_addr,
  output logic                       set_stb,

  output logic [C_ADDRWIDTH-1:0]     get_addr,
  output logic                       get_stb,
  input  logic [C_DATAWIDTH-1:0]     get_data
);

  w_state_t                w_state;
  r_state_t                r_state;
  logic                    aw_held;
  logic                    w_held;
  logic                    strb_ok;
  logic [C_ADDRWIDTH-1:0]  aw_addr_q;
  logic [C_DATAWIDTH-1:0]  w_data_q;

  logic                    aw_fire;
  logic                    w_fire;
  logic                    aw_now;
  logic                    w_now;
  logic                    strb_now;
  logic [C_ADDRWIDTH-1:0]  addr_now;
  logic [C_DATAWIDTH-1:0]  data_now;
  logic                    ar_fire;

  // A channel counts as held if it was captured earlier or is handshaking now.
  assign aw_fire  = s_axi_awvalid & s_axi_awready;
  assign w_fire   = s_axi_wvalid & s_axi_wready;
  assign aw_now   = aw_held | aw_fire;
  assign w_now    = w_held | w_fire;
  assign strb_now = w_fire ? (&s_axi_wstrb) : strb_ok;
  assign addr_now = aw_fire ? s_axi_awaddr : aw_addr_q;
  assign data_now = w_fire ? s_axi_wdata : w_data_q;
  assign ar_fire  = s_axi_arvalid & s_axi_arready;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state       <= W_IDLE;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      strb_ok       <= 1'b0;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      set_stb       <= 1'b0;
      set_addr      <= '0;
      set_data      <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_fire) begin
            aw_addr_q <= s_axi_awaddr;
            aw_held   <= 1'b1;
          end
          if (w_fire) begin
            w_data_q <= s_axi_wdata;
            strb_ok  <= &s_axi_wstrb;
            w_held   <= 1'b1;
          end
          if (aw_now && w_now) begin
            w_state       <= W_STROBE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            // Partial writes are refused: the downstream bus has no byte enables.
            set_stb       <= strb_now;
            if (strb_now) begin
              set_addr <= addr_now;
              set_data <= data_now;
            end
          end else begin
            s_axi_awready <= ~aw_now;
            s_axi_wready  <= ~w_now;
          end
        end
        W_STROBE: begin
          set_stb      <= 1'b0;
          s_axi_bvalid <= 1'b1;
          s_axi_bresp  <= strb_ok ? RESP_OKAY : RESP_SLVERR;
          w_state      <= W_RESP;
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: begin
          w_state <= W_IDLE;
        end
      endcase
    end
  end

  // rdata is captured on the strobe edge, so get_data only needs to be valid
  // while get_stb is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rdata   <= '0;
      get_stb       <= 1'b0;
      get_addr      <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_fire) begin
            get_addr      <= s_axi_araddr;
            get_stb       <= 1'b1;
            s_axi_arready <= 1'b0;
            r_state       <= R_STROBE;
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        R_STROBE: begin
          get_stb      <= 1'b0;
          s_axi_rdata  <= get_data;
          s_axi_rvalid <= 1'b1;
          s_axi_rresp  <= RESP_OKAY;
          r_state      <= R_RESP;
        end
        R_RESP: begin
          if (s_axi_rready) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
            r_state       <= R_IDLE;
          end
        end
        default: begin
          r_state <= R_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_settings_bridge.sv
// Directed, table-driven bench for the AXI-Lite settings bridge with a small
// combinational register-file model on the get port.
module tb_axi_lite_settings_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] set_data;
  logic [31:0] set_addr;
  logic        set_stb;
  logic [31:0] get_addr;
  logic        get_stb;
  logic [31:0] get_data;

  int tests_run    = 0;
  int tests_failed = 0;
  int set_cnt      = 0;
  int get_cnt      = 0;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    bit          exp_stb;
  } vec_t;

  vec_t vecs[8];

  axi_lite_settings_bridge #(
    .C_DATAWIDTH (32),
    .C_ADDRWIDTH (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .set_data      (set_data),
    .set_addr      (set_addr),
    .set_stb       (set_stb),
    .get_addr      (get_addr),
    .get_stb       (get_stb),
    .get_data      (get_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    case (a)
      32'h0000_0000: rd_model = 32'hACE0_BA53;
      32'h0000_0014: rd_model = 32'h1414_BEEF;
      32'h0000_0020: rd_model = 32'h0BAD_F00D;
      default:       rd_model = {a[15:0], 16'h5A5A};
    endcase
  endfunction

  // Data is only driven while strobed so a mistimed rdata capture shows up.
  assign get_data = get_stb ? rd_model(get_addr) : 32'h0;

  always @(posedge clk) begin
    if (set_stb) set_cnt++;
    if (get_stb) get_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " awready"},  {31'd0, awready},  32'd0);
    checkOutput({tag, " wready"},   {31'd0, wready},   32'd0);
    checkOutput({tag, " arready"},  {31'd0, arready},  32'd0);
    checkOutput({tag, " bvalid"},   {31'd0, bvalid},   32'd0);
    checkOutput({tag, " bresp"},    {30'd0, bresp},    32'd0);
    checkOutput({tag, " rvalid"},   {31'd0, rvalid},   32'd0);
    checkOutput({tag, " rresp"},    {30'd0, rresp},    32'd0);
    checkOutput({tag, " rdata"},    rdata,             32'd0);
    checkOutput({tag, " set_stb"},  {31'd0, set_stb},  32'd0);
    checkOutput({tag, " set_addr"}, set_addr,          32'd0);
    checkOutput({tag, " set_data"}, set_data,          32'd0);
    checkOutput({tag, " get_stb"},  {31'd0, get_stb},  32'd0);
    checkOutput({tag, " get_addr"}, get_addr,          32'd0);
  endtask

  // Runs one full single-channel transaction with cycle-exact checks.
  task automatic applyStimulus(input vec_t v);
    int cnt0;
    if (v.is_wr) begin
      cnt0 = set_cnt;
      checkOutput("wr awready idle", {31'd0, awready}, 32'd1);
      checkOutput("wr wready idle",  {31'd0, wready},  32'd1);
      awaddr = v.addr; awvalid = 1'b1;
      wdata  = v.data; wstrb = v.strb; wvalid = 1'b1;
      step();
      awvalid = 1'b0; wvalid = 1'b0;
      checkOutput("wr set_stb N+1", {31'd0, set_stb}, {31'd0, v.exp_stb});
      checkOutput("wr bvalid N+1",  {31'd0, bvalid},  32'd0);
      if (v.exp_stb) begin
        checkOutput("wr set_addr", set_addr, v.addr);
        checkOutput("wr set_data", set_data, v.data);
      end
      step();
      checkOutput("wr set_stb N+2", {31'd0, set_stb}, 32'd0);
      checkOutput("wr bvalid N+2",  {31'd0, bvalid},  32'd1);
      checkOutput("wr bresp",       {30'd0, bresp},   {30'd0, v.exp_resp});
      step();
      checkOutput("wr bvalid done", {31'd0, bvalid},  32'd0);
      checkOutput("wr awready back", {31'd0, awready}, 32'd1);
      checkOutput("wr strobe count", set_cnt - cnt0, {31'd0, v.exp_stb});
    end else begin
      cnt0 = get_cnt;
      checkOutput("rd arready idle", {31'd0, arready}, 32'd1);
      araddr = v.addr; arvalid = 1'b1;
      step();
      arvalid = 1'b0;
      checkOutput("rd get_stb N+1",  {31'd0, get_stb}, 32'd1);
      checkOutput("rd get_addr",     get_addr,         v.addr);
      checkOutput("rd arready busy", {31'd0, arready}, 32'd0);
      checkOutput("rd rvalid N+1",   {31'd0, rvalid},  32'd0);
      step();
      checkOutput("rd get_stb N+2",  {31'd0, get_stb}, 32'd0);
      checkOutput("rd rvalid N+2",   {31'd0, rvalid},  32'd1);
      checkOutput("rd rdata",        rdata,            v.exp_data);
      checkOutput("rd rresp",        {30'd0, rresp},   32'd0);
      step();
      checkOutput("rd rvalid done",  {31'd0, rvalid},  32'd0);
      checkOutput("rd strobe count", get_cnt - cnt0,   32'd1);
    end
  endtask

  initial begin
    int snap_set;
    int snap_get;

    vecs[0] = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 32'h0,          2'b00, 1'b1};
    vecs[1] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hACE0_BA53, 2'b00, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0004, 32'h1234_5678, 4'h3, 32'h0,          2'b10, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_000C, 32'hA5A5_A5A5, 4'hF, 32'h0,          2'b00, 1'b1};
    vecs[4] = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, 32'h1414_BEEF, 2'b00, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h0BAD_F00D, 2'b00, 1'b0};
    vecs[6] = '{1'b1, 32'h0000_00FC, 32'h0000_0000, 4'h8, 32'h0,          2'b10, 1'b0};
    vecs[7] = '{1'b0, 32'h0000_0044, 32'h0,         4'h0, 32'h0044_5A5A, 2'b00, 1'b0};

    rst = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    araddr = '0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    step();
    step();
    checkAllZero("reset");
    rst = 1'b0;
    step();
    checkOutput("post-reset awready", {31'd0, awready}, 32'd1);
    checkOutput("post-reset wready",  {31'd0, wready},  32'd1);
    checkOutput("post-reset arready", {31'd0, arready}, 32'd1);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // W arrives three cycles ahead of AW.
    snap_set = set_cnt;
    wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    checkOutput("early W wready drop", {31'd0, wready},  32'd0);
    checkOutput("early W awready",     {31'd0, awready}, 32'd1);
    step();
    checkOutput("early W no stb", {31'd0, set_stb}, 32'd0);
    step();
    awaddr = 32'h0000_0004; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    checkOutput("late AW set_stb",  {31'd0, set_stb}, 32'd1);
    checkOutput("late AW set_addr", set_addr, 32'h0000_0004);
    checkOutput("late AW set_data", set_data, 32'hCAFE_F00D);
    step();
    checkOutput("late AW bvalid", {31'd0, bvalid}, 32'd1);
    checkOutput("late AW bresp",  {30'd0, bresp},  32'd0);
    step();
    checkOutput("late AW one strobe", set_cnt - snap_set, 32'd1);
    checkOutput("late AW hold addr",  set_addr, 32'h0000_0004);

    // Read response held off by rready.
    rready = 1'b0;
    araddr = 32'h0; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    checkOutput("stall get_stb", {31'd0, get_stb}, 32'd1);
    step();
    for (int i = 0; i < 4; i++) begin
      checkOutput("stall rvalid",  {31'd0, rvalid},  32'd1);
      checkOutput("stall rdata",   rdata,            32'hACE0_BA53);
      checkOutput("stall arready", {31'd0, arready}, 32'd0);
      step();
    end
    rready = 1'b1;
    step();
    checkOutput("stall release rvalid", {31'd0, rvalid}, 32'd0);

    // Concurrent write and read.
    awaddr = 32'h0000_0010; awvalid = 1'b1;
    wdata = 32'h600D_CAFE; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 32'h0000_0014; arvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    checkOutput("dual set_stb",  {31'd0, set_stb}, 32'd1);
    checkOutput("dual get_stb",  {31'd0, get_stb}, 32'd1);
    checkOutput("dual set_addr", set_addr, 32'h0000_0010);
    checkOutput("dual set_data", set_data, 32'h600D_CAFE);
    checkOutput("dual get_addr", get_addr, 32'h0000_0014);
    step();
    checkOutput("dual bvalid", {31'd0, bvalid}, 32'd1);
    checkOutput("dual bresp",  {30'd0, bresp},  32'd0);
    checkOutput("dual rvalid", {31'd0, rvalid}, 32'd1);
    checkOutput("dual rdata",  rdata,           32'h1414_BEEF);
    step();

    // Reset with the read in R_RESP and the write in W_STROBE.
    rready = 1'b0;
    araddr = 32'h0000_0020; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    step();
    checkOutput("pre-rst rvalid", {31'd0, rvalid}, 32'd1);
    awaddr = 32'h0000_0030; awvalid = 1'b1;
    wdata = 32'h1111_2222; wstrb = 4'hF; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    checkOutput("pre-rst set_stb", {31'd0, set_stb}, 32'd1);
    rst = 1'b1;
    step();
    snap_set = set_cnt;
    snap_get = get_cnt;
    checkAllZero("mid-rst");
    step();
    rst = 1'b0;
    rready = 1'b1;
    step();
    checkOutput("rst release awready", {31'd0, awready}, 32'd1);
    checkOutput("rst release wready",  {31'd0, wready},  32'd1);
    checkOutput("rst release arready", {31'd0, arready}, 32'd1);
    step();
    checkOutput("abandon bvalid", {31'd0, bvalid}, 32'd0);
    checkOutput("abandon rvalid", {31'd0, rvalid}, 32'd0);
    checkOutput("abandon set cnt", set_cnt - snap_set, 32'd0);
    checkOutput("abandon get cnt", get_cnt - snap_get, 32'd0);
    applyStimulus(vecs[3]);
    applyStimulus(vecs[5]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axi_lite_settings_bridge.md
AXI_LITE_SETTINGS_BRIDGE -- requirements
Module: axi_lite_settings_bridge

Interface
REQ-001 SHALL have parameter C_DATAWIDTH, default 32, the data width of AXI-Lite and settings-bus data.
REQ-002 SHALL have parameter C_ADDRWIDTH, default 32, the address width of AXI-Lite and settings-bus addresses.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 s_axi_awaddr/awvalid/awready  in/in/out  C_ADDRWIDTH/1/1  AXI-Lite write-address channel.
REQ-006 s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  C_DATAWIDTH/C_DATAWIDTH/8/1/1  write-data channel.
REQ-007 s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write-response channel.
REQ-008 s_axi_araddr/arvalid/arready  in/in/out  C_ADDRWIDTH/1/1  read-address channel.
REQ-009 s_axi_rdata/rresp/rvalid/rready  out/out/out/in  C_DATAWIDTH/2/1/1  read-data channel.
REQ-010 set_data/set_addr/set_stb  out  C_DATAWIDTH/C_ADDRWIDTH/1  settings write port to the downstream register block.
REQ-011 get_addr/get_stb  out  C_ADDRWIDTH/1, and get_data  in  C_DATAWIDTH  settings read port; get_data is combinational from get_addr/get_stb.

Function
REQ-012 Write and read paths SHALL be independent FSMs; set_stb and get_stb may assert in the same cycle.
REQ-013 Write FSM states SHALL be W_IDLE, W_STROBE and W_RESP.
REQ-014 In W_IDLE, awready=1 until AW is captured and wready=1 until W is captured; AW and W SHALL be accepted in either order or in the same cycle.
REQ-015 When both AW and W are held, the FSM SHALL go to W_STROBE in the next cycle.
REQ-016 In W_STROBE, set_stb SHALL be high for exactly one cycle with captured set_addr/set_data, when wstrb is all ones; the FSM then goes to W_RESP.
REQ-017 If wstrb is not all ones, set_stb SHALL stay low and bresp SHALL be 2'b10 (SLVERR); otherwise bresp SHALL be 2'b00.
REQ-018 In W_RESP, bvalid SHALL stay high with bresp stable until bready; on the handshake the FSM returns to W_IDLE and the capture flags clear.
REQ-019 Write latency: when both AW and W handshake in cycle N, set_stb SHALL assert in N+1 and bvalid in N+2.
REQ-020 Read FSM states SHALL be R_IDLE, R_STROBE and R_RESP.
REQ-021 In R_IDLE, arready SHALL be 1; on the AR handshake araddr is captured and the FSM goes to R_STROBE.
REQ-022 In R_STROBE, get_stb SHALL be high for exactly one cycle and get_data is registered into rdata at that edge; the FSM then goes to R_RESP.
REQ-023 In R_RESP, rvalid=1 and rresp=2'b00, with rdata stable until rready; the FSM then returns to R_IDLE.
REQ-024 Read latency: AR handshake in cycle N gives get_stb in N+1 and rvalid in N+2.
REQ-025 set_addr/set_data and get_addr SHALL hold their last captured value between strobes.
REQ-026 Only one outstanding transaction per channel is allowed; awready, wready and arready SHALL be low outside their idle-accept conditions.

Reset
REQ-027 While rst is high: both FSMs SHALL go to idle, capture flags clear, and all outputs are 0, including the readies.
REQ-028 Reset mid-transaction SHALL abandon it with no strobe and no response issued.
REQ-029 The readies SHALL assert in the first cycle after rst deasserts.

Structure
REQ-030 A shared package SHALL hold the W_*/R_* state encodings and the response codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
REQ-031 No sub-module is required; the two FSMs SHALL be separate always blocks in one module.

Verification
REQ-032 AW=0x8, W=0xDEADBEEF, wstrb=F in the same cycle, bready=1 -> set_stb one cycle later with set_addr=0x8 and set_data=0xDEADBEEF, then bvalid with bresp=0.
REQ-033 W sent 3 cycles before AW=0x4 -> wready drops after capture and the single set_stb follows the AW handshake.
REQ-034 AR=0x0 with downstream get_data=0xACE0BA53 -> get_stb in N+1, then rvalid and rdata=0xACE0BA53 in N+2; rready held low 4 cycles keeps rvalid and rdata stable.
REQ-035 wstrb=0x3 write -> no set_stb and bresp=2'b10.
REQ-036 Simultaneous write to 0x10 and read of 0x14 -> set_stb and get_stb in the same cycle, with both responses correct.
REQ-037 rst asserted in W_STROBE/R_RESP -> no further strobe or valid, all outputs 0, and a new transaction completes normally afterwards.
